// File: rtl/memory_scheduler_pkg.sv
// rtl/memory_scheduler_pkg.sv - shared access-size codes and alignment helper for the memory scheduler
package memory_scheduler_pkg;

   localparam logic [1:0] DATA_SIZE_BYTE = 2'b00;
   localparam logic [1:0] DATA_SIZE_HALF = 2'b01;
   localparam logic [1:0] DATA_SIZE_WORD = 2'b10;

   // Size code 2'b11 has no defined width, so it always traps.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         DATA_SIZE_BYTE: is_misaligned = 1'b0;
         DATA_SIZE_HALF: is_misaligned = offset[0];
         DATA_SIZE_WORD: is_misaligned = (offset != 2'b00);
         default:        is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/memory_scheduler_if.sv
// rtl/memory_scheduler_if.sv - load/store request port and shared 32-bit memory bus
interface memory_scheduler_if;

   logic        data_req;
   logic        data_write;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ack;
   logic        data_fault;
   logic [31:0] data_rdata;
   logic        data_stall;

   logic [29:0] mem_addr;
   logic        mem_req;
   logic        mem_write;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      input  data_req, data_write, data_size, data_addr, data_wdata,
      output data_ack, data_fault, data_rdata, data_stall,
      output mem_addr, mem_req, mem_write, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output data_req, data_write, data_size, data_addr, data_wdata,
      input  data_ack, data_fault, data_rdata, data_stall,
      input  mem_addr, mem_req, mem_write, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/memory_scheduler_byte_lane_align.sv
// rtl/memory_scheduler_byte_lane_align.sv - big-endian byte-lane enables, write replication and read extraction
module memory_scheduler_byte_lane_align
   import memory_scheduler_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic        misaligned,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext
);

   // Byte offset 0 sits in bits 31:24, so lanes count down from be[3].
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = wdata;
      rdata_ext   = 32'd0;
      misaligned  = is_misaligned(size, offset);
      case (size)
         DATA_SIZE_BYTE: begin
            be          = 4'b1000 >> offset;
            wdata_lanes = {4{wdata[7:0]}};
            case (offset)
               2'd0:    rdata_ext = {24'd0, rdata[31:24]};
               2'd1:    rdata_ext = {24'd0, rdata[23:16]};
               2'd2:    rdata_ext = {24'd0, rdata[15:8]};
               default: rdata_ext = {24'd0, rdata[7:0]};
            endcase
         end
         DATA_SIZE_HALF: begin
            be          = offset[1] ? 4'b0011 : 4'b1100;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = offset[1] ? {16'd0, rdata[15:0]} : {16'd0, rdata[31:16]};
         end
         DATA_SIZE_WORD: begin
            be        = 4'b1111;
            rdata_ext = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/memory_scheduler.sv
// rtl/memory_scheduler.sv - arbitrates the single memory bus between instruction fetch and load/store
module memory_scheduler
   import memory_scheduler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [31:0]         pc_addr,
   output logic                insert_nop,
   output logic                bus_error,
   memory_scheduler_if.master  bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DATA, ST_ERROR} state_t;

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t          state;
   logic [WD_W-1:0] wd;
   logic            timeout_hit;

   logic [3:0]      lane_be;
   logic            misaligned;
   logic [31:0]     lane_wdata;
   logic [31:0]     lane_rdata;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^pc_addr[1:0];

   memory_scheduler_byte_lane_align u_lane (
      .size        (bus.data_size),
      .offset      (bus.data_addr[1:0]),
      .wdata       (bus.data_wdata),
      .rdata       (bus.mem_rdata),
      .be          (lane_be),
      .misaligned  (misaligned),
      .wdata_lanes (lane_wdata),
      .rdata_ext   (lane_rdata)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);

   always_comb begin
      bus.mem_addr   = pc_addr[31:2];
      bus.mem_req    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_be     = 4'b0000;
      bus.mem_wdata  = 32'd0;
      bus.data_ack   = 1'b0;
      bus.data_fault = 1'b0;
      bus.data_rdata = 32'd0;
      insert_nop     = 1'b1;
      case (state)
         ST_FETCH: begin
            bus.mem_req = 1'b1;
            bus.mem_be  = 4'b1111;
            insert_nop  = ~bus.mem_ack;
         end
         ST_DATA: begin
            if (misaligned) begin
               bus.data_ack   = 1'b1;
               bus.data_fault = 1'b1;
            end else begin
               bus.mem_addr  = bus.data_addr[31:2];
               bus.mem_req   = 1'b1;
               bus.mem_write = bus.data_write;
               bus.mem_be    = lane_be;
               bus.mem_wdata = lane_wdata;
               if (bus.mem_ack) begin
                  bus.data_ack   = 1'b1;
                  bus.data_rdata = lane_rdata;
               end
            end
         end
         default: ;
      endcase
      bus.data_stall = bus.data_req & ~bus.data_ack;
   end

   // A pending load/store is taken after every completed fetch, so the two alternate under load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         wd        <= '0;
         bus_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               wd    <= '0;
               state <= bus.data_req ? ST_DATA : ST_FETCH;
            end
            ST_FETCH: begin
               if (bus.mem_ack) begin
                  wd    <= '0;
                  state <= bus.data_req ? ST_DATA : ST_FETCH;
               end else if (timeout_hit) begin
                  wd        <= '0;
                  state     <= ST_ERROR;
                  bus_error <= 1'b1;
               end else if (TIMEOUT_CYCLES != 0) begin
                  wd <= wd + WD_W'(1);
               end
            end
            ST_DATA: begin
               if (misaligned || bus.mem_ack) begin
                  wd    <= '0;
                  state <= ST_FETCH;
               end else if (timeout_hit) begin
                  wd        <= '0;
                  state     <= ST_ERROR;
                  bus_error <= 1'b1;
               end else if (TIMEOUT_CYCLES != 0) begin
                  wd <= wd + WD_W'(1);
               end
            end
            default: begin
               wd        <= '0;
               bus_error <= 1'b1;
            end
         endcase
      end
   end

endmodule
